// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_defs: shared constants and types for the multi-cycle MIPS-subset control
// unit. It holds the opcode/func encodings, the ALU_OP, PC_s, w_r_s and
// wr_data_s codes, the state encodings and the instruction-class struct.
// Small helper functions decode the ALU operation for R-type and
// immediate instructions.
package mc_defs;

    localparam int MC_STATE_W  = 4;
    localparam int MC_ALU_OP_W = 3;

    typedef enum logic [MC_STATE_W-1:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_EXR = 4'd2,
        S_WBR = 4'd3,
        S_EXI = 4'd4,
        S_WBI = 4'd5,
        S_MA  = 4'd6,
        S_MR  = 4'd7,
        S_WBL = 4'd8,
        S_MW  = 4'd9,
        S_BR  = 4'd10,
        S_J   = 4'd11,
        S_JR  = 4'd12
    } state_e;

    // Opcodes (Inst_code[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type func codes (Inst_code[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101011;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // ALU operation codes
    localparam logic [MC_ALU_OP_W-1:0] ALU_AND = 3'b000;
    localparam logic [MC_ALU_OP_W-1:0] ALU_OR  = 3'b001;
    localparam logic [MC_ALU_OP_W-1:0] ALU_XOR = 3'b010;
    localparam logic [MC_ALU_OP_W-1:0] ALU_NOR = 3'b011;
    localparam logic [MC_ALU_OP_W-1:0] ALU_ADD = 3'b100;
    localparam logic [MC_ALU_OP_W-1:0] ALU_SUB = 3'b101;
    localparam logic [MC_ALU_OP_W-1:0] ALU_SLT = 3'b110;
    localparam logic [MC_ALU_OP_W-1:0] ALU_SLL = 3'b111;

    // PC next-select codes
    localparam logic [1:0] PCS_INC  = 2'b00;
    localparam logic [1:0] PCS_REG  = 2'b01;
    localparam logic [1:0] PCS_BR   = 2'b10;
    localparam logic [1:0] PCS_JMP  = 2'b11;

    // Write-register select codes
    localparam logic [1:0] WRS_RD   = 2'b00;
    localparam logic [1:0] WRS_RT   = 2'b01;
    localparam logic [1:0] WRS_R31  = 2'b10;

    // Write-data select codes
    localparam logic [1:0] WDS_ALU  = 2'b00;
    localparam logic [1:0] WDS_MEM  = 2'b01;
    localparam logic [1:0] WDS_PC   = 2'b10;

    // One-hot instruction class
    typedef struct packed {
        logic r;
        logic jr;
        logic imm;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic ill;
    } iclass_t;

    // R-type func -> ALU op; an unknown func falls back to add.
    function automatic logic [MC_ALU_OP_W-1:0] alu_from_func(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_XOR:  return ALU_XOR;
            FN_NOR:  return ALU_NOR;
            FN_SLT:  return ALU_SLT;
            FN_SLL:  return ALU_SLL;
            default: return ALU_ADD;
        endcase
    endfunction

    // Immediate-class opcode -> ALU op
    function automatic logic [MC_ALU_OP_W-1:0] imm_alu(input logic [5:0] op);
        case (op)
            OP_ANDI:  return ALU_AND;
            OP_ORI:   return ALU_OR;
            OP_XORI:  return ALU_XOR;
            OP_SLTIU: return ALU_SLT;
            default:  return ALU_ADD;
        endcase
    endfunction

    // Logical immediates are zero-extended; arithmetic/compare are sign-extended.
    function automatic logic imm_sext(input logic [5:0] op);
        return !(op == OP_ANDI || op == OP_ORI || op == OP_XORI);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: bundle between the control unit and the datapath.
// master: the control FSM. It receives OP/func/ZF and drives the selects,
//         enables and debug state.
// slave : the datapath side, with the opposite directions.
interface mc_ctrl_fsm_if;
    logic [5:0]                      OP;
    logic [5:0]                      func;
    logic                            ZF;
    logic [1:0]                      PC_s;
    logic                            Write_PC;
    logic                            Write_IR;
    logic                            Write_Reg;
    logic                            Mem_Write;
    logic [mc_defs::MC_ALU_OP_W-1:0] ALU_OP;
    logic [1:0]                      w_r_s;
    logic [1:0]                      wr_data_s;
    logic                            imm_s;
    logic                            rt_imm_s;
    logic [mc_defs::MC_STATE_W-1:0]  state;

    modport master (
        input  OP, func, ZF,
        output PC_s, Write_PC, Write_IR, Write_Reg, Mem_Write, ALU_OP,
               w_r_s, wr_data_s, imm_s, rt_imm_s, state
    );

    modport slave (
        output OP, func, ZF,
        input  PC_s, Write_PC, Write_IR, Write_Reg, Mem_Write, ALU_OP,
               w_r_s, wr_data_s, imm_s, rt_imm_s, state
    );
endinterface

// File: rtl/mc_ctrl_fsm_instr_class_dec.sv
// instr_class_dec: combinational OP/func -> one-hot instruction class.
// Ports: op_i (Inst_code[31:26]), func_i (Inst_code[5:0]),
//        cls_o (one-hot {R, JR, IMM, LW, SW, BEQ, BNE, J, JAL, ILL}).
module instr_class_dec
    import mc_defs::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    output iclass_t    cls_o
);
    always_comb begin
        cls_o = '0;
        case (op_i)
            OP_RTYPE: begin
                if (func_i == FN_JR) cls_o.jr = 1'b1;
                else                 cls_o.r  = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTIU: cls_o.imm = 1'b1;
            OP_LW:   cls_o.lw  = 1'b1;
            OP_SW:   cls_o.sw  = 1'b1;
            OP_BEQ:  cls_o.beq = 1'b1;
            OP_BNE:  cls_o.bne = 1'b1;
            OP_J:    cls_o.j   = 1'b1;
            OP_JAL:  cls_o.jal = 1'b1;
            default: cls_o.ill = 1'b1;
        endcase
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control unit for the MIPS-subset CPU.
// The unit steps through IF/ID/EX/MEM/WB states. It drives the PC select,
// the write enables and the datapath mux selects every cycle.
// Ports: clk, rst (async active-high); bus (mc_ctrl_fsm_if.master) carrying
//        OP/func/ZF in and PC_s, Write_*, Mem_Write, ALU_OP, w_r_s,
//        wr_data_s, imm_s, rt_imm_s, state out.
module mc_ctrl_fsm
    import mc_defs::*;
#(
    parameter int STATE_W  = 4,
    parameter int ALU_OP_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    mc_ctrl_fsm_if.master  bus
);
    state_e  state_q, state_d;
    iclass_t cls;

    logic [1:0]             pc_s;
    logic                   wpc, wir, wreg, mw, imm, rti;
    logic [MC_ALU_OP_W-1:0] alu;
    logic [1:0]             wrs, wds;

    instr_class_dec u_dec (
        .op_i   (bus.OP),
        .func_i (bus.func),
        .cls_o  (cls)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    // Next-state logic. Only the class bits steer the sequence.
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:  state_d = S_ID;
            S_ID: begin
                if      (cls.r)              state_d = S_EXR;
                else if (cls.jr)             state_d = S_JR;
                else if (cls.imm)            state_d = S_EXI;
                else if (cls.lw || cls.sw)   state_d = S_MA;
                else if (cls.beq || cls.bne) state_d = S_BR;
                else if (cls.j || cls.jal)   state_d = S_J;
                else if (cls.ill)            state_d = S_IF;  // NOP: PC already advanced
            end
            S_EXR: state_d = S_WBR;
            S_EXI: state_d = S_WBI;
            S_MA:  state_d = cls.lw ? S_MR : (cls.sw ? S_MW : S_IF);
            S_MR:  state_d = S_WBL;
            default: state_d = S_IF;  // WB/MW/BR/J/JR and unreachable codes
        endcase
    end

    // Output logic. Reset forces everything to its idle values even though
    // state_q already reads S_IF.
    always_comb begin
        pc_s = PCS_INC;
        wpc  = 1'b0;
        wir  = 1'b0;
        wreg = 1'b0;
        mw   = 1'b0;
        alu  = ALU_ADD;
        wrs  = WRS_RD;
        wds  = WDS_ALU;
        imm  = 1'b0;
        rti  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    wir = 1'b1;
                    wpc = 1'b1;
                end
                S_EXR: alu = alu_from_func(bus.func);
                S_WBR: begin
                    alu  = alu_from_func(bus.func);
                    wreg = 1'b1;
                end
                S_EXI, S_WBI: begin
                    rti = 1'b1;
                    imm = imm_sext(bus.OP);
                    alu = imm_alu(bus.OP);
                    if (state_q == S_WBI) begin
                        wreg = 1'b1;
                        wrs  = WRS_RT;
                    end
                end
                // The address (base + sext offset) stays on the ALU for
                // the whole memory access, including the store cycle.
                S_MA, S_MR, S_MW, S_WBL: begin
                    rti = 1'b1;
                    imm = 1'b1;
                    if (state_q == S_MW) mw = 1'b1;
                    if (state_q == S_WBL) begin
                        wreg = 1'b1;
                        wrs  = WRS_RT;
                        wds  = WDS_MEM;
                    end
                end
                S_BR: begin
                    alu = ALU_SUB;
                    imm = 1'b1;
                    if ((cls.beq && bus.ZF) || (cls.bne && !bus.ZF)) begin
                        wpc  = 1'b1;
                        pc_s = PCS_BR;
                    end
                end
                S_J: begin
                    wpc  = 1'b1;
                    pc_s = PCS_JMP;
                    // jal links the PC that S_IF already advanced
                    if (cls.jal) begin
                        wreg = 1'b1;
                        wrs  = WRS_R31;
                        wds  = WDS_PC;
                    end
                end
                S_JR: begin
                    wpc  = 1'b1;
                    pc_s = PCS_REG;
                end
                default: ;
            endcase
        end
    end

    assign bus.PC_s      = pc_s;
    assign bus.Write_PC  = wpc;
    assign bus.Write_IR  = wir;
    assign bus.Write_Reg = wreg;
    assign bus.Mem_Write = mw;
    assign bus.ALU_OP    = ALU_OP_W'(alu);
    assign bus.w_r_s     = wrs;
    assign bus.wr_data_s = wds;
    assign bus.imm_s     = imm;
    assign bus.rt_imm_s  = rti;
    assign bus.state     = STATE_W'(state_q);
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm. Each instruction is expanded by a reference model
// into the per-cycle state/output sequence the control rules imply. That
// sequence is then compared cycle by cycle, including the S_IF that
// follows, so any stall cycle is caught.
module tb_mc_ctrl_fsm;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mc_ctrl_fsm_if bus();

    mc_ctrl_fsm #(.STATE_W(4), .ALU_OP_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       wpc, wir, wreg, mw;
        logic [1:0] pcs;
        logic       alu_c;
        logic [2:0] alu;
        logic [1:0] wrs, wds;
        logic       imm_c, imm, rti;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e;
        e.st = st; e.wpc = 0; e.wir = 0; e.wreg = 0; e.mw = 0; e.pcs = 0;
        e.alu_c = 0; e.alu = 0; e.wrs = 0; e.wds = 0;
        e.imm_c = 0; e.imm = 0; e.rti = 0;
        return e;
    endfunction

    // ALU op required for an R-type func (unknown -> add)
    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h20: return 3'b100;
            6'h22: return 3'b101;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            6'h26: return 3'b010;
            6'h27: return 3'b011;
            6'h2B: return 3'b110;
            6'h00: return 3'b111;
            default: return 3'b100;
        endcase
    endfunction

    // Expand one instruction into its expected cycle sequence.
    function automatic void build(input logic [31:0] ins, input logic zf);
        logic [5:0] op, fn;
        logic [2:0] a;
        logic       sx, tk;
        exp_t       e;
        op = ins[31:26];
        fn = ins[5:0];
        exp_q.delete();
        e = blank(0); e.wpc = 1; e.wir = 1; e.pcs = 2'b00; exp_q.push_back(e);
        exp_q.push_back(blank(1));
        if (op == 6'h00 && fn == 6'h08) begin
            e = blank(12); e.wpc = 1; e.pcs = 2'b01; exp_q.push_back(e);
        end else if (op == 6'h00) begin
            a = r_alu(fn);
            e = blank(2); e.alu_c = 1; e.alu = a; exp_q.push_back(e);
            e = blank(3); e.alu_c = 1; e.alu = a; e.wreg = 1; exp_q.push_back(e);
        end else if (op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0E || op == 6'h0B) begin
            case (op)
                6'h0C:   begin a = 3'b000; sx = 0; end
                6'h0D:   begin a = 3'b001; sx = 0; end
                6'h0E:   begin a = 3'b010; sx = 0; end
                6'h0B:   begin a = 3'b110; sx = 1; end
                default: begin a = 3'b100; sx = 1; end
            endcase
            e = blank(4); e.alu_c = 1; e.alu = a; e.imm_c = 1; e.imm = sx; e.rti = 1;
            exp_q.push_back(e);
            e.st = 5; e.wreg = 1; e.wrs = 2'b01; e.wds = 2'b00; exp_q.push_back(e);
        end else if (op == 6'h23 || op == 6'h2B) begin
            e = blank(6); e.alu_c = 1; e.alu = 3'b100; e.imm_c = 1; e.imm = 1; e.rti = 1;
            exp_q.push_back(e);
            if (op == 6'h23) begin
                exp_q.push_back(blank(7));
                e = blank(8); e.wreg = 1; e.wrs = 2'b01; e.wds = 2'b01; exp_q.push_back(e);
            end else begin
                e = blank(9); e.mw = 1; exp_q.push_back(e);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            tk = (op == 6'h04) ? zf : !zf;
            e = blank(10); e.alu_c = 1; e.alu = 3'b101; e.imm_c = 1; e.imm = 1; e.rti = 0;
            e.wpc = tk; e.pcs = 2'b10; exp_q.push_back(e);
        end else if (op == 6'h02 || op == 6'h03) begin
            e = blank(11); e.wpc = 1; e.pcs = 2'b11;
            if (op == 6'h03) begin e.wreg = 1; e.wrs = 2'b10; e.wds = 2'b10; end
            exp_q.push_back(e);
        end
    endfunction

    task automatic check_step(input string ctx, input exp_t e);
        chk({ctx, " state"},     32'(bus.state),     32'(e.st));
        chk({ctx, " Write_PC"},  32'(bus.Write_PC),  32'(e.wpc));
        chk({ctx, " Write_IR"},  32'(bus.Write_IR),  32'(e.wir));
        chk({ctx, " Write_Reg"}, 32'(bus.Write_Reg), 32'(e.wreg));
        chk({ctx, " Mem_Write"}, 32'(bus.Mem_Write), 32'(e.mw));
        if (e.wpc)   chk({ctx, " PC_s"},   32'(bus.PC_s),   32'(e.pcs));
        if (e.alu_c) chk({ctx, " ALU_OP"}, 32'(bus.ALU_OP), 32'(e.alu));
        if (e.wreg) begin
            chk({ctx, " w_r_s"},     32'(bus.w_r_s),     32'(e.wrs));
            chk({ctx, " wr_data_s"}, 32'(bus.wr_data_s), 32'(e.wds));
        end
        if (e.imm_c) begin
            chk({ctx, " imm_s"},    32'(bus.imm_s),    32'(e.imm));
            chk({ctx, " rt_imm_s"}, 32'(bus.rt_imm_s), 32'(e.rti));
        end
    endtask

    // Expects to be called while the DUT sits in S_IF, away from a clock edge.
    // Returns just after the edge that re-enters S_IF.
    task automatic run_instr(input logic [31:0] ins, input logic zf);
        string ctx;
        ctx = $sformatf("ins=%08h zf=%0d", ins, zf);
        build(ins, zf);
        bus.OP = ins[31:26];
        bus.func = ins[5:0];
        bus.ZF = zf;
        #1;
        foreach (exp_q[i]) begin
            if (i > 0) begin @(posedge clk); #1; end
            check_step($sformatf("%s c%0d", ctx, i), exp_q[i]);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string ctx);
        chk({ctx, " state"},     32'(bus.state),     32'd0);
        chk({ctx, " Write_PC"},  32'(bus.Write_PC),  32'd0);
        chk({ctx, " Write_IR"},  32'(bus.Write_IR),  32'd0);
        chk({ctx, " Write_Reg"}, 32'(bus.Write_Reg), 32'd0);
        chk({ctx, " Mem_Write"}, 32'(bus.Mem_Write), 32'd0);
        chk({ctx, " PC_s"},      32'(bus.PC_s),      32'd0);
        chk({ctx, " ALU_OP"},    32'(bus.ALU_OP),    32'd4);
        chk({ctx, " w_r_s"},     32'(bus.w_r_s),     32'd0);
        chk({ctx, " wr_data_s"}, 32'(bus.wr_data_s), 32'd0);
        chk({ctx, " imm_s"},     32'(bus.imm_s),     32'd0);
        chk({ctx, " rt_imm_s"},  32'(bus.rt_imm_s),  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] dir_ins[19];
        logic        dir_zf[19];
        logic [5:0]  ops[14];
        logic [5:0]  fns[9];
        logic [31:0] ins;
        logic [5:0]  op, fn;

        dir_ins = '{32'h00221820, 32'h8C220004, 32'hAC220004, 32'h10220003, 32'h10220003,
                    32'h14220003, 32'h14220003, 32'h0C000010, 32'h03E00008, 32'hFC000000,
                    32'h20220005, 32'h3022FFFF, 32'h3422FFFF, 32'h3822FFFF, 32'h2C22FFFF,
                    32'h08000020, 32'h00221822, 32'h00221040, 32'h0022183F};
        dir_zf  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ops = '{6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0B,
                6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B, 6'h00, 6'h08};

        rst = 1'b1;
        bus.OP = '0;
        bus.func = '0;
        bus.ZF = 1'b0;
        #3;
        check_idle("reset");
        @(posedge clk); #1;
        check_idle("reset held");
        #2 rst = 1'b0;
        #1;

        foreach (dir_ins[i]) run_instr(dir_ins[i], dir_zf[i]);

        // Reset in the middle of an add: state drops to S_IF at once,
        // nothing is enabled while held, then a fresh fetch starts.
        bus.OP = 6'h00; bus.func = 6'h20; bus.ZF = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid EXR state", 32'(bus.state), 32'd2);
        #2 rst = 1'b1;
        #1;
        check_idle("async reset");
        @(posedge clk); #1;
        check_idle("reset over edge");
        rst = 1'b0;
        #1;
        chk("release state",    32'(bus.state),    32'd0);
        chk("release Write_IR", 32'(bus.Write_IR), 32'd1);
        chk("release Write_PC", 32'(bus.Write_PC), 32'd1);
        run_instr(32'h00221820, 1'b0);

        for (int n = 0; n < 60; n++) begin
            int k;
            k = int'($urandom_range(0, 14));
            op = (k == 14) ? 6'($urandom) : ops[k];
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 8)];
            ins = {op, 20'($urandom), fn};
            run_instr(ins, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
